wb_trace_buffer: RTL and testbench

//  Synthesizable, parametrised write-back trace recorder. It supersedes $display-based pipeline dumps.

---
 rtl/wb_trace_buffer_pkg.sv | 13 +
 rtl/wb_trace_buffer_ram.sv | 23 ++
 rtl/wb_trace_buffer.sv | 98 +++++++++
 tb/tb_wb_trace_buffer.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/wb_trace_buffer_pkg.sv
// wb_trace_buffer_pkg: FSM state encodings and trigger-mode codes for the write-back trace buffer
package wb_trace_buffer_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ARMED = 2'b01,
    ST_POST  = 2'b10,
    ST_DONE  = 2'b11
  } state_e;
  localparam logic [1:0] TRIG_MANUAL = 2'b00;
  localparam logic [1:0] TRIG_PC     = 2'b01;
  localparam logic [1:0] TRIG_REG    = 2'b10;
  localparam logic [1:0] TRIG_NEVER  = 2'b11;
endpackage

// File: rtl/wb_trace_buffer_ram.sv
// wb_trace_buffer_ram: single write port, registered read port; out-of-range reads return zero
module wb_trace_buffer_ram #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int W     = 101
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_rd_ok,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);
  logic [W-1:0] r_mem [DEPTH];
  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  // Same-slot read/write in one cycle returns the old contents.
  always_ff @(posedge clk or negedge rst)
    if (!rst) o_rdata <= '0;
    else      o_rdata <= i_rd_ok ? r_mem[i_raddr] : '0;
endmodule

// File: rtl/wb_trace_buffer.sv
// wb_trace_buffer: write-back trace recorder with programmable trigger and post-trigger window
module wb_trace_buffer
  import wb_trace_buffer_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int DEPTH   = 16,
  parameter int CYC_W   = 32,
  parameter int IDX_W   = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               arm_i,
  input  logic [1:0]         trig_mode_i,
  input  logic               trig_i,
  input  logic [DATA_W-1:0]  trig_pc_i,
  input  logic [RADDR_W-1:0] trig_reg_i,
  input  logic [IDX_W:0]     post_cnt_i,
  input  logic               wb_en_i,
  input  logic [DATA_W-1:0]  wb_pc_i,
  input  logic [RADDR_W-1:0] wb_addr_i,
  input  logic [DATA_W-1:0]  wb_data_i,
  input  logic [IDX_W-1:0]   rd_idx_i,
  output logic [CYC_W-1:0]   rd_cyc_o,
  output logic [DATA_W-1:0]  rd_pc_o,
  output logic [RADDR_W-1:0] rd_addr_o,
  output logic [DATA_W-1:0]  rd_data_o,
  output logic [IDX_W:0]     count_o,
  output logic [1:0]         state_o,
  output logic               done_o
);
  localparam int ENT_W = CYC_W + DATA_W + RADDR_W + DATA_W;
  localparam logic [IDX_W:0] FULL = (IDX_W+1)'(DEPTH);
  state_e             r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_wr_ptr, w_oldest, w_rd_addr;
  logic [IDX_W:0]     r_count, r_post, r_post_lim, w_post_nxt;
  logic [CYC_W-1:0]   r_cyc;
  logic [ENT_W-1:0]   w_rd_word;
  logic               w_cap, w_trig, w_rd_ok;
  assign w_trig = (trig_mode_i == TRIG_NEVER) ? 1'b0 :
                  (trig_mode_i == TRIG_PC)    ? wb_en_i & (wb_pc_i == trig_pc_i) :
                  (trig_mode_i == TRIG_REG)   ? wb_en_i & (wb_addr_i == trig_reg_i) :
                  (trig_mode_i == TRIG_MANUAL) & trig_i;
  assign w_cap     = wb_en_i & ~arm_i & (r_state == ST_ARMED || r_state == ST_POST);
  // Once the ring has filled, the write pointer sits on the oldest entry.
  assign w_oldest  = (r_count == FULL) ? r_wr_ptr : '0;
  assign w_rd_addr = w_oldest + rd_idx_i;
  assign w_rd_ok   = {1'b0, rd_idx_i} < r_count;
  always_comb begin
    w_state_nxt = r_state;
    w_post_nxt  = r_post;
    if (arm_i) begin
      w_state_nxt = ST_ARMED;
      w_post_nxt  = '0;
    end else if (r_state == ST_ARMED && w_trig) begin
      w_post_nxt  = {{IDX_W{1'b0}}, wb_en_i};
      w_state_nxt = (w_post_nxt >= r_post_lim) ? ST_DONE : ST_POST;
    end else if (r_state == ST_POST && wb_en_i) begin
      w_post_nxt  = r_post + (IDX_W+1)'(1);
      w_state_nxt = (w_post_nxt >= r_post_lim) ? ST_DONE : ST_POST;
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_post     <= '0;
      r_post_lim <= '0;
      r_cyc      <= '0;
    end else begin
      r_cyc   <= r_cyc + CYC_W'(1);
      r_state <= w_state_nxt;
      r_post  <= w_post_nxt;
      if (arm_i) begin
        r_wr_ptr   <= '0;
        r_count    <= '0;
        r_post_lim <= (post_cnt_i > FULL) ? FULL : post_cnt_i;
      end else if (w_cap) begin
        r_wr_ptr <= r_wr_ptr + IDX_W'(1);
        r_count  <= (r_count == FULL) ? r_count : r_count + (IDX_W+1)'(1);
      end
    end
  wb_trace_buffer_ram #(.DEPTH(DEPTH), .AW(IDX_W), .W(ENT_W)) u_ram (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_cap),
    .i_waddr (r_wr_ptr),
    .i_wdata ({r_cyc, wb_pc_i, wb_addr_i, wb_data_i}),
    .i_rd_ok (w_rd_ok),
    .i_raddr (w_rd_addr),
    .o_rdata (w_rd_word)
  );
  assign {rd_cyc_o, rd_pc_o, rd_addr_o, rd_data_o} = w_rd_word;
  assign count_o = r_count;
  assign state_o = r_state;
  assign done_o  = (r_state == ST_DONE);
endmodule

// File: tb/tb_wb_trace_buffer.sv
// tb_wb_trace_buffer: directed stimulus with a queued scoreboard checked by an independent monitor
module tb_wb_trace_buffer;
  logic        clk = 0, rst = 1, arm_i = 0, trig_i = 0, wb_en_i = 0;
  logic [1:0]  trig_mode_i = 0;
  logic [31:0] trig_pc_i = 0, wb_pc_i = 0, wb_data_i = 0;
  logic [4:0]  trig_reg_i = 0, wb_addr_i = 0, post_cnt_i = 0;
  logic [3:0]  rd_idx_i = 0;
  logic [31:0] rd_cyc_o, rd_pc_o, rd_data_o;
  logic [4:0]  rd_addr_o, count_o;
  logic [1:0]  state_o;
  logic        done_o;
  int checks = 0, errors = 0;
  int unsigned tb_cyc = 0;
  logic [31:0] m_cyc;
  logic [31:0] wq[$];
  typedef struct {
    string       nm;
    int unsigned due;
    int          kind;
    logic [31:0] cyc, pc, data;
    logic [4:0]  addr, cnt;
    logic [1:0]  st;
  } exp_t;
  exp_t sq[$];
  wb_trace_buffer dut (
    .clk(clk), .rst(rst), .arm_i(arm_i), .trig_mode_i(trig_mode_i), .trig_i(trig_i),
    .trig_pc_i(trig_pc_i), .trig_reg_i(trig_reg_i), .post_cnt_i(post_cnt_i),
    .wb_en_i(wb_en_i), .wb_pc_i(wb_pc_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
    .rd_idx_i(rd_idx_i), .rd_cyc_o(rd_cyc_o), .rd_pc_o(rd_pc_o), .rd_addr_o(rd_addr_o),
    .rd_data_o(rd_data_o), .count_o(count_o), .state_o(state_o), .done_o(done_o)
  );
  always #5 clk = ~clk;
  always @(posedge clk) tb_cyc <= tb_cyc + 1;
  // Reference cycle count: value the DUT stamps on a write clocked at the next edge.
  always @(posedge clk or negedge rst)
    if (!rst) m_cyc <= 0;
    else      m_cyc <= m_cyc + 1;
  function automatic logic [127:0] rd_word();
    return {rd_cyc_o, rd_pc_o, rd_addr_o, rd_data_o};
  endfunction
  function automatic logic [127:0] st_word();
    return {count_o, state_o, done_o};
  endfunction
  function automatic void check(string nm, logic [127:0] got, logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endfunction
  initial forever begin
    @(posedge clk);
    #1;
    while (sq.size() > 0 && sq[0].due <= tb_cyc) begin
      exp_t e;
      e = sq.pop_front();
      if (e.kind == 0) check(e.nm, st_word(), {e.cnt, e.st, e.st == 2'b11});
      else             check(e.nm, rd_word(), {e.cyc, e.pc, e.addr, e.data});
    end
  end
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic wb(input logic [31:0] pc, input logic [4:0] a, input logic [31:0] d);
    wb_en_i = 1; wb_pc_i = pc; wb_addr_i = a; wb_data_i = d;
    wq.push_back(m_cyc);
    tick();
    wb_en_i = 0;
  endtask
  task automatic arm(input logic [1:0] mode, input logic [4:0] lim);
    arm_i = 1; trig_mode_i = mode; post_cnt_i = lim;
    wq.delete();
    tick();
    arm_i = 0;
  endtask
  task automatic trig();
    trig_i = 1;
    tick();
    trig_i = 0;
  endtask
  task automatic push_rd(input string nm, input logic [31:0] cyc, input logic [31:0] pc,
                         input logic [4:0] a, input logic [31:0] d);
    exp_t e;
    e.nm = nm; e.due = tb_cyc + 1; e.kind = 1;
    e.cyc = cyc; e.pc = pc; e.addr = a; e.data = d; e.cnt = 0; e.st = 0;
    sq.push_back(e);
  endtask
  task automatic exp_status(input string nm, input logic [4:0] cnt, input logic [1:0] st);
    exp_t e;
    e.nm = nm; e.due = tb_cyc + 1; e.kind = 0;
    e.cyc = 0; e.pc = 0; e.addr = 0; e.data = 0; e.cnt = cnt; e.st = st;
    sq.push_back(e);
    tick();
  endtask
  task automatic exp_rd(input string nm, input logic [3:0] idx, input logic [31:0] cyc,
                        input logic [31:0] pc, input logic [4:0] a, input logic [31:0] d);
    rd_idx_i = idx;
    push_rd(nm, cyc, pc, a, d);
    tick();
  endtask
  initial begin
    #2 rst = 0;
    #1;
    check("reset_status", st_word(), 0);
    check("reset_rd", rd_word(), 0);
    tick();
    rst = 1;
    tick();
    arm(2'b00, 5'd3);
    for (int k = 0; k < 5; k++) wb(32'h100 + 4 * k, 5'(k + 1), 32'hA0 + k);
    trig();
    exp_status("m0_post", 5, 2'b10);
    for (int k = 5; k < 8; k++) wb(32'h100 + 4 * k, 5'(k + 1), 32'hA0 + k);
    exp_status("m0_done", 8, 2'b11);
    exp_rd("m0_idx0", 0, wq[0], 32'h100, 5'd1, 32'hA0);
    exp_rd("m0_idx7", 7, wq[7], 32'h11C, 5'd8, 32'hA7);
    exp_rd("m0_idx8_zero", 8, 0, 0, 0, 0);
    wb(32'h300, 5'd9, 32'hFF);
    exp_status("m0_frozen", 8, 2'b11);
    trig_pc_i = 32'h20;
    arm(2'b01, 5'd4);
    for (int k = 0; k < 32; k++) wb(4 * k, 5'(k), 32'h1000 + k);
    exp_status("m1_done", 12, 2'b11);
    exp_rd("m1_idx0", 0, wq[0], 32'h0, 5'd0, 32'h1000);
    exp_rd("m1_newest", 11, wq[11], 32'h2C, 5'd11, 32'h100B);
    exp_rd("m1_idx12_zero", 12, 0, 0, 0, 0);
    arm(2'b11, 5'd0);
    for (int k = 0; k < 20; k++) wb(32'h200 + 4 * k, 5'(k), k);
    exp_status("wrap_status", 16, 2'b01);
    exp_rd("wrap_idx0", 0, wq[4], 32'h210, 5'd4, 32'd4);
    exp_rd("wrap_idx15", 15, wq[19], 32'h24C, 5'd19, 32'd19);
    rd_idx_i = 0;
    push_rd("latency_new", wq[4], 32'h210, 5'd4, 32'd4);
    #1;
    check("latency_hold", rd_word(), {wq[19], 32'h24C, 5'd19, 32'd19});
    tick();
    trig_reg_i = 5;
    arm(2'b10, 5'd2);
    wb(32'h400, 5'd1, 32'h11);
    wb(32'h404, 5'd2, 32'h22);
    exp_status("prio_pre", 2, 2'b01);
    arm_i = 1; post_cnt_i = 0;
    wb_en_i = 1; wb_pc_i = 32'h408; wb_addr_i = 5'd5; wb_data_i = 32'h33;
    tick();
    arm_i = 0; wb_en_i = 0;
    wq.delete();
    exp_status("prio_arm", 0, 2'b01);
    wb(32'h40C, 5'd5, 32'h44);
    exp_status("post0_done", 1, 2'b11);
    exp_rd("post0_idx0", 0, wq[0], 32'h40C, 5'd5, 32'h44);
    exp_rd("post0_idx1_zero", 1, 0, 0, 0, 0);
    arm(2'b00, 5'd5);
    wb(32'h500, 5'd7, 32'h55);
    wb(32'h504, 5'd8, 32'h56);
    trig();
    wb(32'h508, 5'd9, 32'h57);
    exp_status("midpost_status", 3, 2'b10);
    exp_rd("midpost_idx0", 0, wq[0], 32'h500, 5'd7, 32'h55);
    #2 rst = 0;
    #1;
    check("midpost_rst_status", st_word(), 0);
    check("midpost_rst_rd", rd_word(), 0);
    tick();
    rst = 1;
    tick();
    wb(32'h5FC, 5'd2, 32'h5A);
    exp_status("idle_nocap", 0, 2'b00);
    arm(2'b11, 5'd0);
    wb(32'h600, 5'd3, 32'h66);
    exp_rd("post_rst_stamp", 0, wq[0], 32'h600, 5'd3, 32'h66);
    for (int i = 0; i < 20 && sq.size() > 0; i++) tick();
    if (sq.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
